// File: rtl/spartan_expand_if.sv
// Handshake bundle for spartan_expand: input word stream in, packed pair stream out.
// FLUSH / DOUT_PARTIAL exist only when SPARTAN_EXPAND_FLUSH_EN is defined.
interface spartan_expand_if #(
  parameter int INPUT_WIDTH = 32
);
  logic [INPUT_WIDTH-1:0]   DIN;
  logic                     DIN_VAL;
  logic                     DIN_RDY;
  logic [2*INPUT_WIDTH-1:0] DOUT;
  logic                     DOUT_VAL;
  logic                     DOUT_RDY;
`ifdef SPARTAN_EXPAND_FLUSH_EN
  logic                     FLUSH;
  logic                     DOUT_PARTIAL;

  // Producer/consumer side that talks to the packer.
  modport master (
    output DIN, DIN_VAL, DOUT_RDY, FLUSH,
    input  DIN_RDY, DOUT, DOUT_VAL, DOUT_PARTIAL
  );

  // Packer side.
  modport slave (
    input  DIN, DIN_VAL, DOUT_RDY, FLUSH,
    output DIN_RDY, DOUT, DOUT_VAL, DOUT_PARTIAL
  );
`else
  // Producer/consumer side that talks to the packer.
  modport master (
    output DIN, DIN_VAL, DOUT_RDY,
    input  DIN_RDY, DOUT, DOUT_VAL
  );

  // Packer side.
  modport slave (
    input  DIN, DIN_VAL, DOUT_RDY,
    output DIN_RDY, DOUT, DOUT_VAL
  );
`endif
endinterface

// File: rtl/spartan_expand.sv
// spartan_expand: packs two consecutive INPUT_WIDTH words into one 2*INPUT_WIDTH
// word (first word in the low half). Output is a single registered slot.
// Optional flush of an unpaired low half: define SPARTAN_EXPAND_FLUSH_EN.
module spartan_expand #(
  parameter int INPUT_WIDTH = 32
) (
  input  logic           CLK,
  input  logic           RST,
  spartan_expand_if.slave bus
);

  localparam int OUT_WIDTH = 2 * INPUT_WIDTH;

  typedef enum logic {
    EMPTY = 1'b0,  // no low half held
    HALF  = 1'b1   // low half waiting for its partner
  } state_e;

  state_e                 state_q, state_d;
  logic [INPUT_WIDTH-1:0] low_q, low_d;
  logic [OUT_WIDTH-1:0]   dout_q, dout_d;
  logic                   dout_val_q, dout_val_d;
`ifdef SPARTAN_EXPAND_FLUSH_EN
  logic                   partial_q, partial_d;
  logic                   pend_q, pend_d;
`endif

  logic out_free;
  logic din_rdy;
  logic in_xfer;

  // The output slot can take new data if it is empty or being drained now.
  assign out_free = !dout_val_q || bus.DOUT_RDY;
  // A first word never needs the output slot; a second word does.
  assign din_rdy  = (state_q == EMPTY) || out_free;
  assign in_xfer  = bus.DIN_VAL && din_rdy;

  assign bus.DIN_RDY  = din_rdy;
  assign bus.DOUT     = dout_q;
  assign bus.DOUT_VAL = dout_val_q;
`ifdef SPARTAN_EXPAND_FLUSH_EN
  assign bus.DOUT_PARTIAL = partial_q;
`endif

  // Next-state: pack words, drain the output slot, and handle flush requests.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    low_d      = low_q;
    dout_d     = dout_q;
    dout_val_d = dout_val_q && !bus.DOUT_RDY;  // drained unless reloaded below
`ifdef SPARTAN_EXPAND_FLUSH_EN
    partial_d  = partial_q;
    pend_d     = pend_q;
`endif

    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          low_d   = bus.DIN;
          state_d = HALF;
        end
      end
      HALF: begin
        if (in_xfer) begin
          // A completing word always wins over any flush request.
          dout_d     = {bus.DIN, low_q};
          dout_val_d = 1'b1;
          state_d    = EMPTY;
`ifdef SPARTAN_EXPAND_FLUSH_EN
          partial_d  = 1'b0;
          pend_d     = 1'b0;
`endif
        end
`ifdef SPARTAN_EXPAND_FLUSH_EN
        else if (pend_q && out_free) begin
          dout_d     = {{INPUT_WIDTH{1'b0}}, low_q};
          dout_val_d = 1'b1;
          partial_d  = 1'b1;
          pend_d     = 1'b0;
          state_d    = EMPTY;
        end else if (bus.FLUSH) begin
          pend_d = 1'b1;
        end
`endif
      end
      default: state_d = EMPTY;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (RST) begin
      state_q    <= EMPTY;
      // NOTE: the held low word is reset as well, so a discarded half can never reappear on DOUT.
      low_q      <= '0;
      dout_q     <= '0;
      dout_val_q <= 1'b0;
`ifdef SPARTAN_EXPAND_FLUSH_EN
      partial_q  <= 1'b0;
      pend_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      low_q      <= low_d;
      dout_q     <= dout_d;
      dout_val_q <= dout_val_d;
`ifdef SPARTAN_EXPAND_FLUSH_EN
      partial_q  <= partial_d;
      pend_q     <= pend_d;
`endif
    end
  end

endmodule
